// File: rtl/key_matrix_scanner.sv
`timescale 1ns/1ps
// key_matrix_scanner
//    Scans an N_COL x N_ROW key matrix one column at a time. The active column is
//    driven low and the pulled-up row lines are sensed back. Every key is debounced
//    over whole scan frames. Press/release events are queued in a small FIFO and
//    read out through a valid/ready handshake.
//
//    Optional feature (macro KEYSCAN_AUTOREPEAT_EN): the most recently pressed key
//    auto-repeats while held. The first repeat comes after REPEAT_DELAY frames, then
//    one every REPEAT_RATE frames. A repeat is skipped, not deferred, when the FIFO
//    is full.
//
// Ports
//    CLK        in   system clock
//    RESET      in   synchronous, active-high reset
//    Col_Drive  out  one-cold column drive, 0 = column active
//    Row_Sense  in   row inputs, pulled up, 0 = key closed
//    Key_Code   out  col*N_ROW + row of the head event
//    Key_Press  out  1 = press event, 0 = release event
//    Key_Valid  out  head event available
//    Key_Ready  in   consumer accepts the head event
//    Overflow   out  sticky: an event was deferred because the FIFO was full
module key_matrix_scanner #(
   parameter int N_ROW        = 8,
   parameter int N_COL        = 8,
   parameter int SCAN_DIV     = 26999,
   parameter int DEBOUNCE     = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100
) (
   input  logic                           CLK,
   input  logic                           RESET,
   output logic [N_COL-1:0]               Col_Drive,
   input  logic [N_ROW-1:0]               Row_Sense,
   output logic [$clog2(N_ROW*N_COL)-1:0] Key_Code,
   output logic                           Key_Press,
   output logic                           Key_Valid,
   input  logic                           Key_Ready,
   output logic                           Overflow
);

   localparam int N_KEY  = N_ROW * N_COL;
   localparam int CODE_W = $clog2(N_KEY);
   localparam int CNT_W  = $clog2(SCAN_DIV + 1);
   localparam int DB_W   = $clog2(DEBOUNCE + 1);
   localparam int ROW_W  = (N_ROW > 1) ? $clog2(N_ROW) : 1;
   localparam int COL_W  = (N_COL > 1) ? $clog2(N_COL) : 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCNT_W = PTR_W + 1;

   localparam logic [N_COL-1:0] ONE_COL = {{(N_COL-1){1'b0}}, 1'b1};

   localparam logic [1:0] ST_SETTLE  = 2'd0;
   localparam logic [1:0] ST_SAMPLE  = 2'd1;
   localparam logic [1:0] ST_EVAL    = 2'd2;
   localparam logic [1:0] ST_ADVANCE = 2'd3;

   logic [1:0]          state;
   logic [CNT_W-1:0]    scan_cnt;
   logic [COL_W-1:0]    col;
   logic [ROW_W-1:0]    row_idx;
   logic [N_ROW-1:0]    row_latch;      // 1 = key closed in the sampled column
   logic [N_KEY-1:0]    stable;         // debounced state, 1 = pressed
   logic [DB_W-1:0]     db_cnt [N_KEY];
   logic [CODE_W:0]     fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic [FCNT_W-1:0]   fifo_cnt;

   logic [COL_W-1:0]    col_inc;
   logic [CODE_W-1:0]   key_idx;
   logic                sample;
   logic                cur_stable;
   logic [DB_W-1:0]     cur_cnt;
   logic [DB_W-1:0]     db_cnt_next;
   logic                is_eval;
   logic                pop;
   logic                can_push;
   logic                db_toggle;
   logic                db_defer;
   logic                rep_push;
   logic                push_ok;
   logic [CODE_W:0]     push_data;
   logic [CODE_W:0]     head_next;
   logic [PTR_W-1:0]    rd_next;
   logic [FCNT_W-1:0]   fifo_left;
   logic [FCNT_W-1:0]   fifo_cnt_next;

   assign is_eval    = (state == ST_EVAL);
   assign key_idx    = CODE_W'(int'(col) * N_ROW + int'(row_idx));
   assign sample     = row_latch[row_idx];
   assign cur_stable = stable[key_idx];
   assign cur_cnt    = db_cnt[key_idx];
   assign pop        = Key_Valid & Key_Ready;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign can_push   = (fifo_cnt != FCNT_W'(FIFO_DEPTH)) | pop;
   assign push_ok    = db_toggle | rep_push;
   assign push_data  = db_toggle ? {key_idx, ~cur_stable} : {key_idx, 1'b1};

   // Next column index with wrap.
   always_comb begin
      col_inc = col;
      if (col == COL_W'(N_COL - 1)) begin
         col_inc = '0;
      end else begin
         col_inc = col + COL_W'(1);
      end
   end

   // Debounce decision for the key under evaluation.
   always_comb begin
      db_cnt_next = cur_cnt;
      db_toggle   = 1'b0;
      db_defer    = 1'b0;
      if (!is_eval) begin
         db_cnt_next = cur_cnt;
      end else if (sample == cur_stable) begin
         db_cnt_next = '0;
      end else if (cur_cnt >= DB_W'(DEBOUNCE - 1)) begin
         if (can_push) begin
            db_toggle   = 1'b1;
            db_cnt_next = '0;
         end else begin
            // Hold at the threshold so the same event is retried next frame.
            db_defer    = 1'b1;
            db_cnt_next = DB_W'(DEBOUNCE);
         end
      end else begin
         db_cnt_next = cur_cnt + DB_W'(1);
      end
   end

   // FIFO bookkeeping and the value the registered head outputs load next.
   always_comb begin
      rd_next       = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
      fifo_left     = pop ? fifo_cnt - FCNT_W'(1) : fifo_cnt;
      fifo_cnt_next = push_ok ? fifo_left + FCNT_W'(1) : fifo_left;
      if (fifo_left == '0) begin
         head_next = push_data;
      end else begin
         head_next = fifo_mem[rd_next];
      end
   end

   // Scan sequencer: column drive, settle counter, row sampling, row stepping.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ST_SETTLE;
         scan_cnt  <= '0;
         col       <= '0;
         row_idx   <= '0;
         row_latch <= '0;
         Col_Drive <= '1;
      end else begin
         // Free-running so that EVAL/ADVANCE overlap the next column's settle time.
         scan_cnt <= (scan_cnt == CNT_W'(SCAN_DIV)) ? '0 : scan_cnt + CNT_W'(1);
         case (state)
            ST_SETTLE: begin
               Col_Drive <= ~(ONE_COL << col);
               if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               row_latch <= ~Row_Sense;
               row_idx   <= '0;
               state     <= ST_EVAL;
            end
            ST_EVAL: begin
               if (row_idx == ROW_W'(N_ROW - 1)) begin
                  state <= ST_ADVANCE;
               end else begin
                  row_idx <= row_idx + ROW_W'(1);
               end
            end
            ST_ADVANCE: begin
               col       <= col_inc;
               Col_Drive <= ~(ONE_COL << col_inc);
               state     <= ST_SETTLE;
            end
            default: begin
               state <= ST_SETTLE;
            end
         endcase
      end
   end

   // Per-key debounce state and the sticky overflow flag.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         stable   <= '0;
         Overflow <= 1'b0;
         for (int k = 0; k < N_KEY; k++) begin
            db_cnt[k] <= '0;
         end
      end else begin
         if (is_eval) begin
            db_cnt[key_idx] <= db_cnt_next;
            if (db_toggle) begin
               stable[key_idx] <= ~cur_stable;
            end
         end
         if (db_defer) begin
            Overflow <= 1'b1;
         end
      end
   end

   // Event storage; contents need no reset because the pointers define validity.
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         fifo_mem[wr_ptr] <= push_data;
      end
   end

   // FIFO pointers and the registered head-of-queue outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         fifo_cnt  <= '0;
         Key_Valid <= 1'b0;
         Key_Code  <= '0;
         Key_Press <= 1'b0;
      end else begin
         rd_ptr    <= rd_next;
         wr_ptr    <= push_ok ? wr_ptr + PTR_W'(1) : wr_ptr;
         fifo_cnt  <= fifo_cnt_next;
         Key_Valid <= (fifo_cnt_next != '0);
         if (fifo_cnt_next != '0) begin
            {Key_Code, Key_Press} <= head_next;
         end
      end
   end

`ifdef KEYSCAN_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RP_W    = $clog2(REP_MAX + 1);

   logic [CODE_W-1:0] rep_key;
   logic              rep_on;
   logic              rep_first;
   logic [RP_W-1:0]   rep_cnt;
   logic              rep_tick;
   logic              rep_hit;

   // One tick per frame while the repeating key is steadily held.
   assign rep_tick = is_eval && rep_on && (key_idx == rep_key) &&
                     (sample == cur_stable) && cur_stable;

   // Decide whether this frame's tick is due for a repeat event.
   always_comb begin
      rep_hit  = 1'b0;
      rep_push = 1'b0;
      if (rep_tick) begin
         if (rep_first) begin
            rep_hit = ((rep_cnt + RP_W'(1)) >= RP_W'(REPEAT_DELAY));
         end else begin
            rep_hit = ((rep_cnt + RP_W'(1)) >= RP_W'(REPEAT_RATE));
         end
         rep_push = rep_hit & can_push;
      end else begin
         rep_hit  = 1'b0;
         rep_push = 1'b0;
      end
   end

   // Track the most recently pressed key and its repeat timing.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rep_key   <= '0;
         rep_on    <= 1'b0;
         rep_first <= 1'b0;
         rep_cnt   <= '0;
      end else if (db_toggle) begin
         if (!cur_stable) begin
            rep_key   <= key_idx;
            rep_on    <= 1'b1;
            rep_first <= 1'b1;
            rep_cnt   <= '0;
         end else if (key_idx == rep_key) begin
            rep_on <= 1'b0;
         end
      end else if (rep_tick) begin
         if (rep_hit) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else begin
            rep_cnt <= rep_cnt + RP_W'(1);
         end
      end
   end
`else
   assign rep_push = 1'b0;
`endif

endmodule

// File: tb/tb_key_matrix_scanner.sv
`timescale 1ns/1ps
// Scoreboard bench for key_matrix_scanner: a behavioural matrix drives Row_Sense
// from the currently closed keys, stimulus pushes the expected events, and a
// monitor pops and compares every accepted event.
module tb_key_matrix_scanner;
   localparam int N_ROW = 8;
   localparam int N_COL = 8;
   localparam int SCAN_DIV = 15;
   localparam int DEBOUNCE = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int FRAME = N_COL * (SCAN_DIV + 1);

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] Col_Drive;
   logic [7:0] Row_Sense;
   logic [5:0] Key_Code;
   logic       Key_Press;
   logic       Key_Valid;
   logic       Key_Ready;
   logic       Overflow;

   logic [N_ROW-1:0] key_mat [N_COL];   // 1 = key closed
   logic [6:0]       sb_q [$];          // {code, press}
   int n_tests = 0;
   int n_fail  = 0;
   int n_pops  = 0;
   int ready_mode = 1;                  // 0 = low, 1 = high, 2 = random

   key_matrix_scanner #(
      .N_ROW(N_ROW), .N_COL(N_COL), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
      .FIFO_DEPTH(FIFO_DEPTH), .REPEAT_DELAY(3), .REPEAT_RATE(2)
   ) dut (
      .CLK(CLK), .RESET(RESET), .Col_Drive(Col_Drive), .Row_Sense(Row_Sense),
      .Key_Code(Key_Code), .Key_Press(Key_Press), .Key_Valid(Key_Valid),
      .Key_Ready(Key_Ready), .Overflow(Overflow)
   );

   always #5 CLK = ~CLK;

   // Ideal matrix: a closed key pulls its row low while its column is driven low.
   always_comb begin
      Row_Sense = 8'hFF;
      for (int c = 0; c < N_COL; c++) begin
         if (!Col_Drive[c]) Row_Sense = Row_Sense & ~key_mat[c];
      end
   end

   task automatic chk(input logic ok, input string name, input string detail);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   task automatic set_key(input int code, input logic closed);
      key_mat[code / N_ROW][code % N_ROW] = closed;
   endtask

   task automatic expect_ev(input int code, input logic press);
      sb_q.push_back({6'(code), press});
   endtask

   task automatic wait_frames(input int n);
      repeat (n * FRAME) @(posedge CLK);
      #1;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int i = 0;
      while (sb_q.size() != 0 && i < budget) begin
         @(posedge CLK);
         #1;
         i++;
      end
      chk(sb_q.size() == 0, name, $sformatf("%0d events still expected after %0d clks, want 0",
          sb_q.size(), budget));
   endtask

   // Key_Ready driver; changes only just after a rising edge.
   initial begin
      Key_Ready = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         case (ready_mode)
            0:       Key_Ready = 1'b0;
            1:       Key_Ready = 1'b1;
            default: Key_Ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pop/compare accepted events and check head stability while stalled.
   initial begin
      logic       held;
      logic [6:0] held_ev;
      logic [6:0] exp_ev;
      held = 1'b0;
      held_ev = '0;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            held = 1'b0;
         end else begin
            if (held) begin
               chk(Key_Valid && ({Key_Code, Key_Press} == held_ev), "head_stable",
                   $sformatf("valid=%0d code=%0d press=%0d, want valid=1 code=%0d press=%0d",
                   Key_Valid, Key_Code, Key_Press, held_ev[6:1], held_ev[0]));
            end
            if (Key_Valid && Key_Ready) begin
               n_pops++;
               if (sb_q.size() == 0) begin
                  chk(1'b0, "unexpected_event", $sformatf("got code=%0d press=%0d, want none",
                      Key_Code, Key_Press));
               end else begin
                  exp_ev = sb_q.pop_front();
                  chk({Key_Code, Key_Press} == exp_ev, "event",
                      $sformatf("got code=%0d press=%0d, want code=%0d press=%0d",
                      Key_Code, Key_Press, exp_ev[6:1], exp_ev[0]));
               end
               held = 1'b0;
            end else begin
               held    = Key_Valid;
               held_ev = {Key_Code, Key_Press};
            end
         end
      end
   end

   // Watchdog.
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      int pops0;
      int code;
      int hold;
      logic ok;
      for (int c = 0; c < N_COL; c++) key_mat[c] = '0;
      RESET = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk(Col_Drive == 8'hFF, "rst_col", $sformatf("got %h, want ff", Col_Drive));
      chk(Key_Valid == 1'b0 && Key_Code == 6'd0 && Key_Press == 1'b0, "rst_key",
          $sformatf("got valid=%0d code=%0d press=%0d, want 0/0/0", Key_Valid, Key_Code, Key_Press));
      chk(Overflow == 1'b0, "rst_ovf", $sformatf("got %0d, want 0", Overflow));
      RESET = 1'b0;
      @(posedge CLK);
      #1;
      chk(Col_Drive == 8'hFE, "first_col", $sformatf("got %h, want fe", Col_Drive));

      // 1: idle scan, columns step every SCAN_DIV+1 clocks and wrap.
      begin
         int i = 0;
         while (Col_Drive != 8'hFD && i < 64) begin
            @(posedge CLK);
            #1;
            i++;
         end
         chk(Col_Drive == 8'hFD, "col1_reach", $sformatf("got %h, want fd", Col_Drive));
      end
      for (int k = 0; k < 17; k++) begin
         logic [7:0] one;
         logic [7:0] exp_col;
         one = 8'd1;
         exp_col = ~(one << ((k + 1) % N_COL));
         ok = 1'b1;
         for (int j = 0; j < SCAN_DIV + 1; j++) begin
            if (Col_Drive != exp_col) ok = 1'b0;
            @(posedge CLK);
            #1;
         end
         chk(ok, "col_step", $sformatf("step %0d got %h, want %h for %0d clks", k, Col_Drive,
             exp_col, SCAN_DIV + 1));
      end
      chk(Key_Valid == 1'b0, "idle_valid", $sformatf("got %0d, want 0", Key_Valid));

      // 2: one clean press and release of col 2 row 5.
      ready_mode = 1;
      expect_ev(21, 1'b1);
      set_key(21, 1'b1);
      wait_frames(3);
      expect_ev(21, 1'b0);
      set_key(21, 1'b0);
      wait_frames(3);
      wait_drain(FRAME, "drain_t2");

      // 3: single-frame bounces must not produce events.
      pops0 = n_pops;
      for (int b = 0; b < 2; b++) begin
         set_key(0, 1'b1);
         wait_frames(1);
         set_key(0, 1'b0);
         wait_frames(2);
      end
      wait_frames(1);
      chk(n_pops == pops0, "bounce", $sformatf("got %0d events, want 0", n_pops - pops0));

`ifndef KEYSCAN_AUTOREPEAT_EN
      // 4: six events against a four-entry FIFO with the consumer stalled.
      ready_mode = 0;
      expect_ev(10, 1'b1); set_key(10, 1'b1); wait_frames(3);
      expect_ev(30, 1'b1); set_key(30, 1'b1); wait_frames(3);
      expect_ev(45, 1'b1); set_key(45, 1'b1); wait_frames(3);
      expect_ev(10, 1'b0); set_key(10, 1'b0); wait_frames(3);
      chk(Overflow == 1'b0, "ovf_at_full", $sformatf("got %0d, want 0", Overflow));
      expect_ev(30, 1'b0); set_key(30, 1'b0); wait_frames(3);
      chk(Overflow == 1'b1, "ovf_set", $sformatf("got %0d, want 1", Overflow));
      expect_ev(45, 1'b0); set_key(45, 1'b0); wait_frames(3);
      ready_mode = 1;
      wait_drain(4 * FRAME, "drain_t4");
      chk(Overflow == 1'b1, "ovf_sticky", $sformatf("got %0d, want 1", Overflow));
`endif

      // 5: reset with events pending discards them.
      ready_mode = 0;
      set_key(50, 1'b1); wait_frames(3);
      set_key(50, 1'b0); wait_frames(3);
      chk(Key_Valid == 1'b1, "pending", $sformatf("got %0d, want 1", Key_Valid));
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      sb_q.delete();
      chk(Key_Valid == 1'b0 && Col_Drive == 8'hFF && Overflow == 1'b0, "mid_reset",
          $sformatf("got valid=%0d col=%h ovf=%0d, want 0/ff/0", Key_Valid, Col_Drive, Overflow));
      RESET = 1'b0;
      @(posedge CLK);
      #1;
      chk(Col_Drive == 8'hFE, "post_reset_col", $sformatf("got %h, want fe", Col_Drive));
      ready_mode = 1;
      pops0 = n_pops;
      wait_frames(3);
      chk(n_pops == pops0, "no_stale", $sformatf("got %0d events, want 0", n_pops - pops0));

`ifdef KEYSCAN_AUTOREPEAT_EN
      // 6: held key repeats after 3 frames, then every 2 frames.
      for (int r = 0; r < 4; r++) expect_ev(9, 1'b1);
      expect_ev(9, 1'b0);
      set_key(9, 1'b1); wait_frames(10);
      set_key(9, 1'b0); wait_frames(3);
      wait_drain(2 * FRAME, "drain_t6");
`endif

      // Random keys, random hold lengths, random consumer stalls.
      ready_mode = 2;
      for (int it = 0; it < 10; it++) begin
         code = int'($urandom_range(0, N_ROW * N_COL - 1));
         hold = int'($urandom_range(1, 4));
         if (hold >= DEBOUNCE) begin
            expect_ev(code, 1'b1);
            expect_ev(code, 1'b0);
         end
         set_key(code, 1'b1);
         wait_frames(hold);
         set_key(code, 1'b0);
         wait_frames(3);
      end
      ready_mode = 1;
      wait_drain(2 * FRAME, "drain_rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
